capture_trigger: RTL and testbench

//  Front-end acquisition stage ahead of the oscilloscope serial path. Synchronises
//  the raw probe pin, samples it at a programmable rate and packs 8 samples/byte

---
 rtl/capture_trigger.sv | 248 ++++++++++++++++++++++++
 tb/tb_capture_trigger.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_trigger.sv
// capture_trigger: probe synchroniser, programmable-rate sampler, and 8:1 bit packer
// feeding a ring buffer with edge trigger and pre-trigger history. After capture,
// the buffer is drained oldest byte first over a valid/ready byte stream.
// Optional feature macro: AUTO_TRIG_EN. When defined, a TMO_W-bit timeout in WAIT
// forces a capture and leaves `triggered` low.
module capture_trigger #(
  parameter int unsigned DEPTH_BYTES = 64,
  parameter int unsigned PRE_BYTES   = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned TMO_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_pin_0,
  input  logic             arm,
  input  logic             trig_rise,
  input  logic [DIV_W-1:0] rate_div,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             triggered,
  output logic             done
);
  localparam int unsigned AW         = $clog2(DEPTH_BYTES);
  localparam int unsigned POST_BYTES = DEPTH_BYTES - PRE_BYTES;
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_BYTES - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_BYTES - 1);
  localparam logic [AW:0]   DRAIN_N   = (AW+1)'(DEPTH_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, rate_q, rate_d;
  logic             rise_q, rise_d, s_prev_q, s_prev_d;
  logic [6:0]       sh_q, sh_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, byte_cnt_q, byte_cnt_d;
  logic [AW:0]      issued_q, issued_d, acc_cnt_q, acc_cnt_d;
  logic             rd_vld_q, rd_vld_d, out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d, rd_data_q;
  logic             trig_q, trig_d, done_q, done_d;
  logic [7:0]       mem [DEPTH_BYTES];

  logic       s, sampling, strobe, wr_en, rd_en, edge_hit, adv, tmo_fire;
  logic [7:0] wr_byte;

`ifdef AUTO_TRIG_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  assign tmo_fire = (tmo_q == '1);
`else
  // Without the auto trigger the timeout can never fire.
  assign tmo_fire = (TMO_W == 0);
`endif

  // Two-flop synchroniser for the asynchronous probe pin.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], input_pin_0};
  end

  // Capture RAM: write on every 8th strobe, registered read during drain.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_byte;
    if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

  // Next-state, sampling, packing and drain pipeline.
  always_comb begin
    s        = sync_q[1];
    sampling = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    strobe   = sampling && (div_cnt_q == rate_q);
    wr_en    = strobe && (bit_cnt_q == 3'd7);
    wr_byte  = {sh_q, s};
    edge_hit = strobe && (rise_q ? (s && !s_prev_q) : (!s && s_prev_q));
    adv      = !out_valid_q || out_ready;
    rd_en    = 1'b0;

    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    rate_d      = rate_q;
    rise_d      = rise_q;
    s_prev_d    = s_prev_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    issued_d    = issued_q;
    acc_cnt_d   = acc_cnt_q;
    rd_vld_d    = rd_vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    trig_d      = trig_q;
    done_d      = 1'b0;
`ifdef AUTO_TRIG_EN
    tmo_d       = tmo_q;
`endif

    if (sampling) begin
      div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);
      if (strobe) begin
        s_prev_d  = s;
        sh_d      = {sh_q[5:0], s};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    end

    case (state_q)
      S_IDLE: begin
        out_valid_d = 1'b0;
        rd_vld_d    = 1'b0;
        trig_d      = 1'b0;
        if (arm) begin
          state_d    = S_PRE;
          rate_d     = rate_div;
          rise_d     = trig_rise;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          wr_ptr_d   = '0;
          byte_cnt_d = '0;
          s_prev_d   = s;
        end
      end
      S_PRE: begin
        if (wr_en) begin
          byte_cnt_d = byte_cnt_q + AW'(1);
          if (byte_cnt_q == PRE_LAST) begin
            state_d    = S_WAIT;
            byte_cnt_d = '0;
`ifdef AUTO_TRIG_EN
            tmo_d      = '0;
`endif
          end
        end
      end
      S_WAIT: begin
`ifdef AUTO_TRIG_EN
        tmo_d = tmo_q + TMO_W'(1);
`endif
        // A byte completed on the trigger strobe was written while still in WAIT,
        // so it stays on the pre-trigger side of the POST byte count.
        if (edge_hit) begin
          state_d = S_POST;
          trig_d  = 1'b1;
        end else if (tmo_fire) begin
          state_d = S_POST;
        end
      end
      S_POST: begin
        if (wr_en) begin
          byte_cnt_d = byte_cnt_q + AW'(1);
          if (byte_cnt_q == POST_LAST) begin
            state_d   = S_DRAIN;
            rd_ptr_d  = wr_ptr_d;
            issued_d  = '0;
            acc_cnt_d = '0;
            rd_vld_d  = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        // Two-stage pipe (RAM data register, output register) keeps one byte per
        // clock with ready held high and stalls both stages under backpressure.
        if (adv) begin
          out_valid_d = rd_vld_q;
          out_data_d  = rd_data_q;
        end
        if (!rd_vld_q || adv) begin
          if (issued_q != DRAIN_N) begin
            rd_en    = 1'b1;
            rd_vld_d = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            issued_d = issued_q + (AW+1)'(1);
          end else begin
            rd_vld_d = 1'b0;
          end
        end
        if (out_valid_q && out_ready) begin
          acc_cnt_d = acc_cnt_q + (AW+1)'(1);
          if (acc_cnt_q == DRAIN_N - (AW+1)'(1)) begin
            done_d      = 1'b1;
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            rd_vld_d    = 1'b0;
            trig_d      = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= '0;
      rate_q      <= '0;
      rise_q      <= 1'b0;
      s_prev_q    <= 1'b0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      issued_q    <= '0;
      acc_cnt_q   <= '0;
      rd_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef AUTO_TRIG_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      rate_q      <= rate_d;
      rise_q      <= rise_d;
      s_prev_q    <= s_prev_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      issued_q    <= issued_d;
      acc_cnt_q   <= acc_cnt_d;
      rd_vld_q    <= rd_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
`ifdef AUTO_TRIG_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign triggered = trig_q;
  assign done      = done_q;
endmodule

// File: tb/tb_capture_trigger.sv
// Bench for capture_trigger. The reference model rebuilds the sample stream from the
// logged pin history: sample k is the pin value 2 edges before strobe edge arm+k*(R+1).
// It then locates the trigger sample and derives the drained window from it.
`timescale 1ns/1ps
module tb_capture_trigger;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned PRE   = 16;
  localparam int unsigned POST  = DEPTH - PRE;
  localparam int unsigned TMO   = 8;

  logic        clk = 1'b0;
  logic        rst, input_pin_0, arm, trig_rise, out_ready;
  logic [15:0] rate_div;
  logic [7:0]  out_data;
  logic        out_valid, busy, triggered, done;

  capture_trigger #(.DEPTH_BYTES(DEPTH), .PRE_BYTES(PRE), .DIV_W(16), .TMO_W(TMO)) dut (
    .clk(clk), .rst(rst), .input_pin_0(input_pin_0), .arm(arm), .trig_rise(trig_rise),
    .rate_div(rate_div), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .triggered(triggered), .done(done)
  );

  always #10 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  bit          pin_hist[$];
  int unsigned arm_idx = 0;
  logic [7:0]  got[$];
  int unsigned first_valid_e, first_acc_e, last_acc_e, done_cnt, done_e, stab_err;
  bit          seen_valid;
  logic        trig_at_valid;
  logic        prev_valid = 1'b0;
  logic [7:0]  prev_data = '0;
  int unsigned cur_r;
  bit          cur_rise;

  // Edge monitor: logs the pin seen at each edge and the handshakes that completed there.
  always @(posedge clk) begin
    int unsigned e;
    #1;
    pin_hist.push_back(input_pin_0);
    e = pin_hist.size() - 1;
    if (arm && !rst) arm_idx = e;
    if (prev_valid && out_ready && !rst) begin
      got.push_back(prev_data);
      if (got.size() == 1) first_acc_e = e;
      last_acc_e = e;
    end
    if (prev_valid && !out_ready && !rst && !(out_valid && out_data == prev_data)) stab_err++;
    if (out_valid && !seen_valid) begin
      seen_valid    = 1'b1;
      first_valid_e = e;
      trig_at_valid = triggered;
    end
    if (done) begin
      done_cnt++;
      done_e = e;
    end
    prev_valid = out_valid;
    prev_data  = out_data;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic bit smp(input int unsigned k);
    return pin_hist[arm_idx + k * (cur_r + 1) - 2];
  endfunction

  // Finds the trigger sample; returns the 1-based index of the final byte written (0 = none).
  function automatic void predict(output int unsigned last, output bit real_trig);
    int unsigned k = 8 * PRE;
    int unsigned w = arm_idx + 8 * PRE * (cur_r + 1);
    bit found = 1'b0;
    real_trig = 1'b0;
    last = 0;
    while (!found && k < 200000) begin
      k++;
`ifdef AUTO_TRIG_EN
      if (arm_idx + k * (cur_r + 1) > w + (1 << TMO)) begin
        found = 1'b1;
        last  = ((w + (1 << TMO) - arm_idx) / (cur_r + 1)) / 8 + POST;
      end else
`endif
      if (arm_idx + k * (cur_r + 1) - 2 >= pin_hist.size()) begin
        found = 1'b1;
      end else if (cur_rise ? (!smp(k-1) && smp(k)) : (smp(k-1) && !smp(k))) begin
        found     = 1'b1;
        real_trig = 1'b1;
        last      = k / 8 + POST;
      end
    end
  endfunction

  function automatic logic [7:0] exp_byte(input int unsigned j);
    logic [7:0] v = '0;
    for (int unsigned b = 0; b < 8; b++) v = {v[6:0], smp(8 * (j - 1) + 1 + b)};
    return v;
  endfunction

  task automatic start(input bit rise, input int unsigned r);
    got.delete();
    seen_valid = 1'b0; done_cnt = 0; stab_err = 0;
    first_acc_e = 0; last_acc_e = 0; first_valid_e = 0; done_e = 0;
    cur_r = r; cur_rise = rise;
    chk("idle_before_arm", busy, 0);
    trig_rise = rise; rate_div = 16'(r); arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // ready_mode: 0 = held high, 1 = toggles every clock, 2 = random.
  task automatic run(input int unsigned budget, input int unsigned pin_at, input bit pin_val,
                     input int unsigned ready_mode, input bit noise);
    for (int unsigned i = 0; i < budget && done_cnt == 0; i++) begin
      if (i == pin_at) input_pin_0 = pin_val;
      if (noise && $urandom_range(0, 39) == 0) input_pin_0 = ~input_pin_0;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      tick();
    end
    chk("done_within_budget", done_cnt != 0, 1);
    repeat (4) tick();
  endtask

  task automatic check_capture(input string tag, input int expect_real, input bit ready_high);
    int unsigned last;
    bit rt;
    predict(last, rt);
    chk({tag, "_trigger_found"}, last != 0, 1);
    if (expect_real >= 0) chk({tag, "_real_trigger"}, rt, expect_real[0]);
    chk({tag, "_triggered_flag"}, trig_at_valid, rt);
    chk({tag, "_byte_count"}, got.size(), DEPTH);
    for (int unsigned j = 0; j < DEPTH && j < got.size(); j++)
      chk($sformatf("%s_byte%0d", tag, j), got[j], exp_byte(last - DEPTH + 1 + j));
    chk({tag, "_valid_latency"}, first_valid_e, arm_idx + 8 * last * (cur_r + 1) + 2);
    if (ready_high) begin
      chk({tag, "_first_accept"}, first_acc_e, first_valid_e + 1);
      chk({tag, "_back_to_back"}, last_acc_e - first_acc_e, DEPTH - 1);
    end
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_done_after_last"}, done_e, last_acc_e);
    chk({tag, "_hold_stable"}, stab_err, 0);
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; input_pin_0 = 1'b0; trig_rise = 1'b1; rate_div = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Rising trigger at full rate, pin rises 200 clocks after arm.
    start(1'b1, 0);
    run(3000, 200, 1'b1, 0, 1'b0);
    check_capture("rise", 1, 1'b1);

    // Falling trigger, one sample every 4 clocks.
    input_pin_0 = 1'b1;
    repeat (5) tick();
    start(1'b0, 3);
    run(8000, 600, 1'b0, 0, 1'b0);
    check_capture("fall", 1, 1'b1);

    // Backpressure with ready toggling every clock and a noisy pin.
    input_pin_0 = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    start(1'($urandom_range(0, 1)), $urandom_range(0, 2));
    run(8000, 32'hFFFF_FFFF, 1'b0, 1, 1'b1);
    check_capture("bp", -1, 1'b0);

    // Randomised captures with random ready.
    for (int unsigned t = 0; t < 2; t++) begin
      repeat (3) tick();
      start(1'($urandom_range(0, 1)), $urandom_range(0, 3));
      run(9000, 32'hFFFF_FFFF, 1'b0, 2, 1'b1);
      check_capture($sformatf("rnd%0d", t), -1, 1'b0);
    end

    // Reset held 3 clocks in the middle of POST aborts the capture.
    input_pin_0 = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    start(1'b1, 0);
    for (int unsigned i = 0; i < 400 && !triggered; i++) begin
      if (i == 200) input_pin_0 = 1'b1;
      tick();
    end
    chk("post_triggered", triggered, 1);
    repeat (20) tick();
    chk("post_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_triggered", triggered, 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_valid", seen_valid, 0);

`ifndef AUTO_TRIG_EN
    // Edge only during PRE: capture waits indefinitely.
    input_pin_0 = 1'b0;
    repeat (3) tick();
    start(1'b1, 0);
    for (int unsigned i = 0; i < 10000; i++) begin
      if (i == 20) input_pin_0 = 1'b1;
      tick();
    end
    chk("pre_edge_busy", busy, 1);
    chk("pre_edge_triggered", triggered, 0);
    chk("pre_edge_no_valid", seen_valid, 0);
    chk("pre_edge_no_done", done_cnt, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
`else
    // Static pin: timeout forces the capture with triggered left low.
    input_pin_0 = 1'b0;
    repeat (3) tick();
    start(1'b1, 0);
    run(3000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    check_capture("auto", 0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
